// File: rtl/tff_pkg.sv
// Shared definitions for the toggle-flip-flop modulo counter.
// Holds default sizing, direction encodings and the toggle-vector helper.
package tff_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_MOD   = 10;

    // Widest counter the toggle helper supports.
    localparam int TOG_W     = 32;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // A T cell must flip exactly the bits that differ between now and next.
    function automatic logic [TOG_W-1:0] toggle_vec(input logic [TOG_W-1:0] cur,
                                                    input logic [TOG_W-1:0] nxt);
        return cur ^ nxt;
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// One-bit T flip-flop with synchronous active-high clear.
module t_ff_cell (
    input  logic clk,
    input  logic clr,
    input  logic t,
    output logic q,
    output logic qbar
);

    // Clear wins; otherwise flip the stored bit when t is high.
    always_ff @(posedge clk) begin
        if (clr)    q <= 1'b0;
        else if (t) q <= ~q;
    end

    assign qbar = ~q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MOD up/down counter whose state bits are T flip-flop cells.
// The next count is computed here and converted to a per-bit toggle vector.
// Optional build macro: TFF_CNT_SAT_EN (saturate at the bounds instead of wrapping).
module tff_mod_counter
    import tff_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MOD   = DEF_MOD
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    // One extra bit so MOD = 2**WIDTH is representable in the range compares.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t;
    logic             wrap_next;
    logic             err_next;
    logic             in_range;
    logic             d_legal;
    logic             at_max;
    logic             at_zero;

    assign in_range = ({1'b0, q} < MOD_EXT);
    assign d_legal  = ({1'b0, d} < MOD_EXT);
    assign at_max   = (q == MAX_Q);
    assign at_zero  = (q == '0);

    // Terminal count is purely combinational so downstream logic sees it before the edge.
    assign tc = en & ((up == DIR_UP) ? at_max : at_zero);

    // Next-state selection: load beats count; clear is applied in the cells/registers.
    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (load) begin
            if (d_legal) q_next   = d;
            else         err_next = 1'b1;
        end else if (en) begin
            if (!in_range) begin
                // Corrupted state: recover silently to zero.
                q_next = '0;
            end else if (up == DIR_UP) begin
                if (at_max) begin
`ifdef TFF_CNT_SAT_EN
                    q_next    = q;
`else
                    q_next    = '0;
                    wrap_next = 1'b1;
`endif
                end else begin
                    q_next = q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
`ifdef TFF_CNT_SAT_EN
                    q_next    = q;
`else
                    q_next    = MAX_Q;
                    wrap_next = 1'b1;
`endif
                end else begin
                    q_next = q - WIDTH'(1);
                end
            end
        end
    end

    assign t = WIDTH'(toggle_vec(TOG_W'(q), TOG_W'(q_next)));

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            t_ff_cell u_cell (
                .clk  (clk),
                .clr  (clr),
                .t    (t[gi]),
                .q    (q[gi]),
                .qbar (qbar[gi])
            );
        end
    endgenerate

    // Registered one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= wrap_next;
            load_err <= err_next;
        end
    end

endmodule

// File: tb/tb_tff_mod_counter.sv
// Scoreboard bench for tff_mod_counter (WIDTH=4, MOD=10).
// Honours TFF_CNT_SAT_EN for the saturating build.
module tb_tff_mod_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         clr, en, up, load;
    logic [W-1:0] d;
    logic [W-1:0] q, qbar;
    logic         tc, wrap, load_err;

    typedef struct {
        logic [W-1:0] q;
        logic         w;
        logic         e;
        logic         tc;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    int   mq;
    int   n_cmp = 0;
    int   n_bad = 0;

    tff_mod_counter #(.WIDTH(W), .MOD(M)) dut (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .d(d),
        .q(q), .qbar(qbar), .tc(tc), .wrap(wrap), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and push the expected post-edge state.
    task automatic drive(input logic c, input logic e, input logic u,
                         input logic l, input int dv);
        exp_t x;
        int   nq;
        @(negedge clk);
        clr = c; en = e; up = u; load = l; d = W'(dv);
        x.tc = e && (u ? (mq == M-1) : (mq == 0));
        x.w  = 1'b0;
        x.e  = 1'b0;
        nq   = mq;
        if (c) nq = 0;
        else if (l) begin
            if (dv < M) nq = dv; else x.e = 1'b1;
        end else if (e) begin
            if (mq >= M) nq = 0;
            else if (u) begin
                if (mq == M-1) begin
`ifdef TFF_CNT_SAT_EN
                    nq = mq;
`else
                    nq = 0; x.w = 1'b1;
`endif
                end else nq = mq + 1;
            end else begin
                if (mq == 0) begin
`ifdef TFF_CNT_SAT_EN
                    nq = 0;
`else
                    nq = M-1; x.w = 1'b1;
`endif
                end else nq = mq - 1;
            end
        end
        mq  = nq;
        x.q = W'(nq);
        sb.push_back(x);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 1, 3);
            @(posedge clk); #1;
            ex = sb.pop_front();
            n_cmp++;
            if (q !== ex.q || qbar !== 4'b1111 || wrap !== 1'b0 || load_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset[%0d]: q=%h qbar=%h wrap=%b err=%b, want q=%h qbar=f wrap=0 err=0",
                         i, q, qbar, wrap, load_err, ex.q);
            end
        end
    endtask

    task automatic test_up_wrap();
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 1, 0, 0);
            n_cmp++;
            if (tc !== sb[$].tc) begin
                n_bad++;
                $display("FAIL up_tc[%0d]: got %b want %b", i, tc, sb[$].tc);
            end
            @(posedge clk); #1;
            ex = sb.pop_front();
            n_cmp++;
            if (q !== ex.q || qbar !== ~ex.q || wrap !== ex.w || load_err !== ex.e) begin
                n_bad++;
                $display("FAIL up_wrap[%0d]: q=%h qbar=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
                         i, q, qbar, wrap, load_err, ex.q, ex.w, ex.e);
            end
        end
    endtask

    task automatic test_down_wrap();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(0, 0, 0, 1, 1);
            else        drive(0, 1, 0, 0, 0);
            n_cmp++;
            if (tc !== sb[$].tc) begin
                n_bad++;
                $display("FAIL down_tc[%0d]: got %b want %b", i, tc, sb[$].tc);
            end
            @(posedge clk); #1;
            ex = sb.pop_front();
            n_cmp++;
            if (q !== ex.q || qbar !== ~ex.q || wrap !== ex.w || load_err !== ex.e) begin
                n_bad++;
                $display("FAIL down_wrap[%0d]: q=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
                         i, q, wrap, load_err, ex.q, ex.w, ex.e);
            end
        end
    endtask

    task automatic test_illegal_load();
        int dv[5] = '{5, 12, 0, 15, 7};
        logic lv[5] = '{1, 1, 0, 1, 1};
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, lv[i], dv[i]);
            @(posedge clk); #1;
            ex = sb.pop_front();
            n_cmp++;
            if (q !== ex.q || load_err !== ex.e || wrap !== ex.w) begin
                n_bad++;
                $display("FAIL illegal_load[%0d]: q=%h err=%b wrap=%b, want q=%h err=%b wrap=%b",
                         i, q, load_err, wrap, ex.q, ex.e, ex.w);
            end
        end
    endtask

    task automatic test_priority();
        // load 4, clr+load+en, load+en, hold, reverse direction at 0, then up again
        logic c[6] = '{0, 1, 0, 0, 0, 0};
        logic e[6] = '{0, 1, 1, 0, 1, 1};
        logic u[6] = '{1, 1, 1, 1, 0, 1};
        logic l[6] = '{1, 1, 1, 0, 0, 0};
        int   dv[6] = '{4, 2, 2, 9, 0, 0};
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                drive(0, 0, 1, 1, 0);
                @(posedge clk); #1;
                ex = sb.pop_front();
                n_cmp++;
                if (q !== ex.q) begin
                    n_bad++;
                    $display("FAIL priority_setup: q=%h want %h", q, ex.q);
                end
            end
            drive(c[i], e[i], u[i], l[i], dv[i]);
            n_cmp++;
            if (tc !== sb[$].tc) begin
                n_bad++;
                $display("FAIL priority_tc[%0d]: got %b want %b", i, tc, sb[$].tc);
            end
            @(posedge clk); #1;
            ex = sb.pop_front();
            n_cmp++;
            if (q !== ex.q || wrap !== ex.w || load_err !== ex.e) begin
                n_bad++;
                $display("FAIL priority[%0d]: q=%h wrap=%b err=%b, want q=%h wrap=%b err=%b",
                         i, q, wrap, load_err, ex.q, ex.w, ex.e);
            end
        end
    endtask

`ifdef TFF_CNT_SAT_EN
    task automatic test_saturate();
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      drive(0, 0, 1, 1, 8);
            else if (i == 5) drive(0, 0, 0, 1, 1);
            else             drive(0, 1, (i < 5), 0, 0);
            n_cmp++;
            if (tc !== sb[$].tc) begin
                n_bad++;
                $display("FAIL sat_tc[%0d]: got %b want %b", i, tc, sb[$].tc);
            end
            @(posedge clk); #1;
            ex = sb.pop_front();
            n_cmp++;
            if (q !== ex.q || wrap !== 1'b0) begin
                n_bad++;
                $display("FAIL saturate[%0d]: q=%h wrap=%b, want q=%h wrap=0", i, q, wrap, ex.q);
            end
        end
    endtask
`endif

    initial begin
        clr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
        mq  = 0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_illegal_load();
        test_priority();
`ifdef TFF_CNT_SAT_EN
        test_saturate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
